// File: rtl/draw_ball.sv
// draw_ball: overlays a 16x16 round ball on the VGA pixel stream.
// The ball's top-left corner (xpos, ypos) is latched once per frame, on the
// rising edge of vblank, so the ball never tears mid-frame. The pipeline has
// two register stages, and every output lags its input by exactly 2 pclk cycles.
//
// Ports
//   pclk, rst_n                       pixel clock; asynchronous reset, active low
//   xpos, ypos            [11:0]      ball top-left from the position controller
//   hcount_in, vcount_in  [10:0]      raster position of the incoming pixel
//   hsync_in, vsync_in, hblnk_in, vblnk_in   incoming timing signals
//   rgb_in                [11:0]      upstream pixel colour (RGB444)
//   *_out                             the same signals delayed by 2 cycles
//   rgb_out               [11:0]      composited colour, aligned with *_out
module draw_ball #(
  parameter logic [11:0] BALL_COLOR = 12'hFFF,
  parameter logic [11:0] BLANK_RGB  = 12'h000,
  parameter int unsigned BALL_SIZE  = 16
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned POS_W = 12;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned EXT_W = 13;
  localparam int unsigned IDX_W = 4;

  // Ball outline: bit c of row r is set when the pixel centre lies within
  // radius 8 of the ball centre, i.e. (2c-15)^2 + (2r-15)^2 <= 256.
  function automatic logic [15:0] shape_row(input logic [IDX_W-1:0] r);
    logic [15:0] m;
    case (r)
      4'd0, 4'd15:  m = 16'h07E0;
      4'd1, 4'd14:  m = 16'h1FF8;
      4'd2, 4'd13:  m = 16'h3FFC;
      4'd3, 4'd4,
      4'd11, 4'd12: m = 16'h7FFE;
      default:      m = 16'hFFFF;
    endcase
    return m;
  endfunction

  // Latched ball position, valid once the first vblank rise has been seen
  logic [POS_W-1:0] x_lat, y_lat;
  logic             ball_valid;

  // Stage 1 registers
  logic [CNT_W-1:0] hcount_d, vcount_d;
  logic             hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic [RGB_W-1:0] rgb_d;
  logic             in_box_d;
  logic [IDX_W-1:0] col_d, row_d;

  // Stage 1 combinational terms (13-bit so x_lat+16 cannot wrap)
  logic [EXT_W-1:0] h_ext_c, v_ext_c, x_ext_c, y_ext_c, x_end_c, y_end_c;
  logic             in_box_c;
  logic [IDX_W-1:0] col_c, row_c;
  logic [15:0]      mask_c;
  logic             hit_c;
  logic             vblnk_rise_c;

  always_comb begin
    h_ext_c  = EXT_W'(hcount_in);
    v_ext_c  = EXT_W'(vcount_in);
    x_ext_c  = EXT_W'(x_lat);
    y_ext_c  = EXT_W'(y_lat);
    x_end_c  = x_ext_c + EXT_W'(BALL_SIZE);
    y_end_c  = y_ext_c + EXT_W'(BALL_SIZE);
    in_box_c = ball_valid &&
               (h_ext_c >= x_ext_c) && (h_ext_c < x_end_c) &&
               (v_ext_c >= y_ext_c) && (v_ext_c < y_end_c);
    // Low 4 bits of the offset depend only on the low 4 bits of the operands
    col_c    = hcount_in[IDX_W-1:0] - x_lat[IDX_W-1:0];
    row_c    = vcount_in[IDX_W-1:0] - y_lat[IDX_W-1:0];
    mask_c   = shape_row(row_d);
    hit_c    = in_box_d && mask_c[col_d];
    vblnk_rise_c = vblnk_in && !vblnk_d;
  end

  // Position latch: sampled only at the vblank rising edge
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat      <= '0;
      y_lat      <= '0;
      ball_valid <= 1'b0;
    end else if (vblnk_rise_c) begin
      x_lat      <= xpos;
      y_lat      <= ypos;
      ball_valid <= 1'b1;
    end
  end

  // Stage 1: register timing, colour and the box hit-test
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_d <= '0;
      vcount_d <= '0;
      hsync_d  <= 1'b0;
      vsync_d  <= 1'b0;
      hblnk_d  <= 1'b0;
      vblnk_d  <= 1'b0;
      rgb_d    <= '0;
      in_box_d <= 1'b0;
      col_d    <= '0;
      row_d    <= '0;
    end else begin
      hcount_d <= hcount_in;
      vcount_d <= vcount_in;
      hsync_d  <= hsync_in;
      vsync_d  <= vsync_in;
      hblnk_d  <= hblnk_in;
      vblnk_d  <= vblnk_in;
      rgb_d    <= rgb_in;
      in_box_d <= in_box_c;
      col_d    <= col_c;
      row_d    <= row_c;
    end
  end

  // Stage 2: shape lookup and colour compositing
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d;
      vcount_out <= vcount_d;
      hsync_out  <= hsync_d;
      vsync_out  <= vsync_d;
      hblnk_out  <= hblnk_d;
      vblnk_out  <= vblnk_d;
      if (hblnk_d || vblnk_d)
        rgb_out <= BLANK_RGB;
      else if (hit_c)
        rgb_out <= BALL_COLOR;
      else
        rgb_out <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_ball.sv
// Testbench for draw_ball: randomized pixel stimulus around the ball box,
// expected responses from a geometric ball model pushed to a scoreboard queue,
// and a monitor that pops and compares once the 2-cycle pipeline is full.
module tb_draw_ball;

  localparam logic [11:0] BALL = 12'hFFF;
  localparam logic [11:0] BLNK = 12'h000;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos, ypos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_ball dut (
    .pclk(pclk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ball_hits = 0;

  // Reference model state: position the ball is currently drawn at
  bit       m_valid;
  int       m_x, m_y;
  bit       m_vprev;

  function automatic bit on_ball(int h, int v, int x, int y);
    int dx, dy;
    dx = h - x;
    dy = v - y;
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return 1'b0;
    return ((2*dx-15)*(2*dx-15) + (2*dy-15)*(2*dy-15)) <= 256;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_x = 0;
    m_y = 0;
    m_vprev = 1'b0;
  endtask

  // Apply one pixel and push what should come out 2 cycles later
  task automatic drive(input int h, input int v, input bit hs, input bit vs,
                       input bit hb, input bit vb, input logic [11:0] rgb);
    exp_t e;
    @(posedge pclk);
    #1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb;
    e.h = 11'(h); e.v = 11'(v);
    e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    if (hb || vb) e.rgb = BLNK;
    else if (m_valid && on_ball(h, v, m_x, m_y)) begin
      e.rgb = BALL;
      ball_hits++;
    end else e.rgb = rgb;
    q.push_back(e);
    // A vblank rise takes effect for the following pixels only
    if (vb && !m_vprev) begin
      m_valid = 1'b1;
      m_x = int'(xpos);
      m_y = int'(ypos);
    end
    m_vprev = vb;
  endtask

  task automatic idle_inputs();
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} != '0) begin
      errors++;
      $display("FAIL %s: outputs h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h, required all 0",
               tag, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out);
    end
  endtask

  task automatic release_reset();
    @(posedge pclk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    q.delete();
    model_reset();
  endtask

  // One frame: optional vblank (latches xpos/ypos), then a 22x22 scan window
  // starting at (sx, sy), wrapping at 1024/768. new_x, when >= 0, is written to
  // xpos halfway through the scan.
  task automatic frame(input bit do_vblank, input int sx, input int sy,
                       input bit fixed_rgb, input logic [11:0] rgb_val,
                       input int new_x);
    if (do_vblank) begin
      for (int i = 0; i < 4; i++) drive(0, 770, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    end
    for (int r = 0; r < 22; r++) begin
      if (r == 11 && new_x >= 0) xpos = 12'(new_x);
      for (int c = 0; c < 22; c++) begin
        logic [11:0] px;
        bit hb;
        px = fixed_rgb ? rgb_val : 12'($urandom);
        hb = ($urandom_range(0, 15) == 0);
        drive((sx + c) % 1024, (sy + r) % 768, 1'($urandom), 1'($urandom), hb, 1'b0, px);
      end
    end
  endtask

  // Monitor: outputs are always valid once the pipeline holds 2 older pixels
  always @(negedge pclk) begin
    if (rst_n === 1'b1 && q.size() > 2) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
          {e.h, e.v, e.hs, e.vs, e.hb, e.vb}) begin
        errors++;
        $display("FAIL timing: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b, required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 e.h, e.v, e.hs, e.vs, e.hb, e.vb);
      end
      checks++;
      if (rgb_out !== e.rgb) begin
        errors++;
        $display("FAIL rgb at (%0d,%0d): got %h, required %h", e.h, e.v, rgb_out, e.rgb);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    xpos = 12'd511;
    ypos = 12'd300;
    idle_inputs();
    model_reset();
    #13;
    check_zero_outputs("reset_state");
    release_reset();

    // No vblank rise yet: the ball must never appear
    frame(1'b0, 505, 295, 1'b0, 12'h000, -1);
    frame(1'b0, 505, 295, 1'b0, 12'h000, -1);

    // Latch (511,300), then draw over a blue background
    frame(1'b1, 509, 298, 1'b1, 12'h00F, -1);
    frame(1'b1, 509, 298, 1'b1, 12'h00F, -1);

    // Mid-frame xpos change is ignored until the next vblank rise
    frame(1'b1, 509, 298, 1'b0, 12'h000, 100);
    frame(1'b1, 98, 298, 1'b0, 12'h000, -1);
    frame(1'b0, 509, 298, 1'b0, 12'h000, -1);

    // Ball hanging off the bottom-right corner; scan wraps to 0
    xpos = 12'd1015;
    ypos = 12'd760;
    frame(1'b1, 1010, 755, 1'b0, 12'h000, -1);
    frame(1'b1, 1010, 755, 1'b0, 12'h000, -1);

    // Off-screen positions: pass-through
    xpos = 12'd1030;
    ypos = 12'd100;
    frame(1'b1, 1010, 95, 1'b0, 12'h000, -1);
    xpos = 12'd200;
    ypos = 12'd900;
    frame(1'b1, 195, 760, 1'b0, 12'h000, -1);

    // Single-signal pulses, including blanking inside the ball box
    xpos = 12'd400;
    ypos = 12'd400;
    frame(1'b1, 398, 398, 1'b1, 12'h0F0, -1);
    drive(407, 407, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F0);
    drive(407, 407, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0);
    drive(407, 407, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0);
    drive(407, 407, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
    drive(407, 407, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F0);
    for (int i = 0; i < 4; i++) drive(408, 407, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);

    // Randomized positions
    for (int f = 0; f < 6; f++) begin
      int rx, ry;
      rx = $urandom_range(0, 1030);
      ry = $urandom_range(0, 775);
      xpos = 12'(rx);
      ypos = 12'(ry);
      frame(1'b1, (rx + 1020) % 1024, (ry + 765) % 768, 1'b0, 12'h000, -1);
    end

    // Asynchronous reset mid-line while the ball is visible
    xpos = 12'd600;
    ypos = 12'd200;
    frame(1'b1, 598, 198, 1'b0, 12'h000, -1);
    for (int c = 0; c < 8; c++) drive(600 + c, 207, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    idle_inputs();
    q.delete();
    repeat (3) @(posedge pclk);
    #1;
    check_zero_outputs("held_reset");
    release_reset();
    // Same frame continues: ball must stay hidden until the next vblank rise
    for (int c = 0; c < 16; c++) drive(600 + c, 208, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
    frame(1'b0, 598, 198, 1'b0, 12'h000, -1);
    frame(1'b1, 598, 198, 1'b0, 12'h000, -1);

    // Flush the pipeline
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(negedge pclk);
    #1;

    checks++;
    if (ball_hits < 100) begin
      errors++;
      $display("FAIL coverage: ball pixels expected %0d, required at least 100", ball_hits);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
